// File: rtl/cp0_pkg.sv
// Shared CP0 write-path definitions: source indices, register addresses and the write payload.
package cp0_pkg;

  localparam int unsigned CP0_AW = 5;
  localparam int unsigned CP0_DW = 32;

  // Write-data source indices; a lower index means higher select priority
  localparam int unsigned SRC_PC       = 0;
  localparam int unsigned SRC_Z        = 1;
  localparam int unsigned SRC_T_STATUS = 2;
  localparam int unsigned SRC_IR       = 3;
  localparam int unsigned SRC_RT       = 4;

  // CP0 register addresses
  localparam logic [CP0_AW-1:0] CP0_STATUS = CP0_AW'(12);
  localparam logic [CP0_AW-1:0] CP0_CAUSE  = CP0_AW'(13);
  localparam logic [CP0_AW-1:0] CP0_EPC    = CP0_AW'(14);

  typedef struct packed {
    logic [CP0_AW-1:0] addr;
    logic [CP0_DW-1:0] data;
  } cp0_wr_t;

endpackage

// File: rtl/cp0_wsel_prio_enc.sv
// Priority mux over packed write-data sources; bit 0 of sel wins, no bit set gives zero.
module cp0_wsel_prio_enc #(
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned WIDTH   = 32
) (
  input  logic [NUM_SRC-1:0]       sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [WIDTH-1:0]         data_c
);

  // Walk from lowest to highest priority so the lowest set bit is written last
  always_comb begin
    data_c = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (sel[i]) data_c = src_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/cp0_wdata_queue.sv
// CP0 write-data queue: selects one of NUM_SRC sources, buffers {addr, data} in a
// DEPTH-entry show-ahead FIFO and drains it to CP0 under a valid/ready handshake.
// Optional multi-select check enabled by defining CP0_WDATA_SELCHK_EN.
module cp0_wdata_queue
  import cp0_pkg::*;
#(
  parameter int unsigned WIDTH   = CP0_DW,
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned AW      = CP0_AW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_req,
  input  logic [AW-1:0]                wr_addr,
  input  logic [NUM_SRC-1:0]           sel,
  input  logic [NUM_SRC*WIDTH-1:0]     src_data,
  output logic                         wr_accept,
  output logic                         cp0_we,
  output logic [AW-1:0]                cp0_waddr,
  output logic [WIDTH-1:0]             cp0_wdata,
  input  logic                         cp0_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow,
  output logic                         sel_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Same layout as cp0_wr_t, but sized by this instance's parameters
  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] sel_data_c;
  logic            full_c;
  logic            push_c;
  logic            pop_c;

  cp0_wsel_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .WIDTH   (WIDTH)
  ) u_prio_enc (
    .sel      (sel),
    .src_data (src_data),
    .data_c   (sel_data_c)
  );

  // A full queue still accepts when the head leaves in the same cycle
  assign full_c     = (count == CW'(DEPTH));
  assign wr_accept  = ~full_c | cp0_ready;
  assign push_c     = wr_req & wr_accept;
  assign pop_c      = cp0_we & cp0_ready;

  // Show-ahead head: outputs are taken straight from registered state
  assign cp0_we     = (count != '0);
  assign cp0_waddr  = mem[rd_ptr].addr;
  assign cp0_wdata  = mem[rd_ptr].data;
  assign fifo_count = count;

  // Storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= '{addr: wr_addr, data: sel_data_c};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_req & ~wr_accept) overflow <= 1'b1;
    end
  end

`ifdef CP0_WDATA_SELCHK_EN
  // Flag pushes whose select vector has more than one bit set
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (push_c) begin
      sel_err <= ($countones(sel) > 1);
    end
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_cp0_wdata_queue.sv
// Scoreboard bench for cp0_wdata_queue: directed scenarios followed by random traffic.
module tb_cp0_wdata_queue;
  import cp0_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_SRC = 5;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned AW      = 5;
  localparam int unsigned SDW     = NUM_SRC * WIDTH;
  localparam int unsigned CW      = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_req;
  logic [AW-1:0]      wr_addr;
  logic [NUM_SRC-1:0] sel;
  logic [SDW-1:0]     src_data;
  logic               wr_accept;
  logic               cp0_we;
  logic [AW-1:0]      cp0_waddr;
  logic [WIDTH-1:0]   cp0_wdata;
  logic               cp0_ready;
  logic [CW-1:0]      fifo_count;
  logic               overflow;
  logic               sel_err;

  int checks = 0;
  int errors = 0;

  // Reference model state (value after the most recent clock edge)
  int      m_count = 0;
  bit      m_ovf   = 0;
  bit      m_selerr = 0;
  cp0_wr_t sb_q [$];

  always #5 clk = ~clk;

  cp0_wdata_queue #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .sel        (sel),
    .src_data   (src_data),
    .wr_accept  (wr_accept),
    .cp0_we     (cp0_we),
    .cp0_waddr  (cp0_waddr),
    .cp0_wdata  (cp0_wdata),
    .cp0_ready  (cp0_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .sel_err    (sel_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rule: lowest set select bit wins, none set gives zero
  function automatic logic [WIDTH-1:0] ref_select(input logic [NUM_SRC-1:0] s, input logic [SDW-1:0] sd);
    for (int i = 0; i < int'(NUM_SRC); i++)
      if (s[i]) return sd[i*WIDTH +: WIDTH];
    return '0;
  endfunction

  // Monitor: every CP0 handshake must deliver the oldest outstanding entry
  always @(negedge clk) begin
    if (rst === 1'b0 && cp0_we === 1'b1 && cp0_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got addr %0h data %0h expected no entry", cp0_waddr, cp0_wdata);
      end else begin
        cp0_wr_t e;
        e = sb_q.pop_front();
        chk("pop_addr", 64'(cp0_waddr), 64'(e.addr));
        chk("pop_data", 64'(cp0_wdata), 64'(e.data));
      end
    end
  end

  // One clock of stimulus; entered and left 1 time unit after a rising edge
  task automatic step(input bit r, input bit req, input logic [AW-1:0] a,
                      input logic [NUM_SRC-1:0] s, input logic [SDW-1:0] sd, input bit rdy);
    bit acc, psh, pp;
    chk("count",    64'(fifo_count), 64'(m_count));
    chk("we",       64'(cp0_we),     64'(m_count != 0));
    chk("overflow", 64'(overflow),   64'(m_ovf));
    chk("sel_err",  64'(sel_err),    64'(m_selerr));
    rst = r; wr_req = req; wr_addr = a; sel = s; src_data = sd; cp0_ready = rdy;
    #1;
    acc = (m_count < int'(DEPTH)) || rdy;
    if (!r) chk("accept", 64'(wr_accept), 64'(acc));
    if (r) begin
      sb_q.delete();
      m_count  = 0;
      m_ovf    = 0;
      m_selerr = 0;
    end else begin
      pp  = (m_count != 0) && rdy;
      psh = req && acc;
      if (psh) begin
        sb_q.push_back('{addr: a, data: ref_select(s, sd)});
`ifdef CP0_WDATA_SELCHK_EN
        m_selerr = ($countones(s) > 1);
`endif
      end
      m_count = m_count + int'(psh) - int'(pp);
      if (req && !acc) m_ovf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SDW-1:0] rand_src();
    logic [SDW-1:0] v;
    for (int i = 0; i < int'(NUM_SRC); i++) v[i*WIDTH +: WIDTH] = $urandom;
    return v;
  endfunction

  function automatic logic [SDW-1:0] with_src(input logic [SDW-1:0] base, input int idx, input logic [WIDTH-1:0] val);
    logic [SDW-1:0] v;
    v = base;
    v[idx*WIDTH +: WIDTH] = val;
    return v;
  endfunction

  task automatic idle(input bit rdy);
    step(0, 0, '0, '0, rand_src(), rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SDW-1:0] sd;
    rst = 1; wr_req = 0; wr_addr = '0; sel = '0; src_data = '0; cp0_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_wdata", 64'(cp0_wdata), 64'(0));
    chk("rst_waddr", 64'(cp0_waddr), 64'(0));

    // 1: single write with 1-cycle latency
    sd = with_src(rand_src(), SRC_T_STATUS, 32'h0000_FF01);
    step(0, 1, 5'd12, 5'b00100, sd, 1);
    chk("t1_wdata", 64'(cp0_wdata), 64'h0000_FF01);
    chk("t1_waddr", 64'(cp0_waddr), 64'd12);
    idle(1);
    idle(1);

    // 2: multiple select bits, lowest wins
    sd = with_src(with_src(rand_src(), SRC_Z, 32'hAAAA_0001), SRC_T_STATUS, 32'hBBBB_0002);
    step(0, 1, CP0_STATUS, 5'b10110, sd, 0);
    chk("t2_wdata", 64'(cp0_wdata), 64'hAAAA_0001);
`ifdef CP0_WDATA_SELCHK_EN
    chk("t2_sel_err", 64'(sel_err), 64'd1);
`else
    chk("t2_sel_err", 64'(sel_err), 64'd0);
`endif
    idle(1);
    idle(1);

    // 3: fill then overflow, drain keeps order and sticky flag
    for (int i = 1; i <= 3; i++)
      step(0, 1, CP0_EPC, 5'b00001, with_src(rand_src(), SRC_PC, 32'(i)), 0);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_count", 64'(fifo_count), 64'd2);
    repeat (3) idle(1);
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);

    // 4: full push and pop in the same cycle
    for (int i = 1; i <= 2; i++)
      step(0, 1, CP0_CAUSE, 5'b01000, with_src(rand_src(), SRC_IR, 32'(i)), 0);
    step(0, 1, CP0_CAUSE, 5'b01000, with_src(rand_src(), SRC_IR, 32'd3), 1);
    chk("t4_count", 64'(fifo_count), 64'd2);
    repeat (3) idle(1);

    // 5: reset mid-drain discards entries and clears overflow
    for (int i = 1; i <= 2; i++)
      step(0, 1, 5'd7, 5'b10000, with_src(rand_src(), SRC_RT, 32'(i + 16)), 0);
    step(1, 0, '0, '0, rand_src(), 0);
    chk("t5_wdata", 64'(cp0_wdata), 64'd0);
    chk("t5_waddr", 64'(cp0_waddr), 64'd0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 5'(i), 5'b00001, with_src(rand_src(), SRC_PC, 32'(100 + i)), 1);
    idle(1);

    // 6: no select bit gives zero data
    step(0, 1, 5'd3, 5'b00000, rand_src(), 0);
    chk("t6_wdata", 64'(cp0_wdata), 64'd0);
    idle(1);
    idle(1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NUM_SRC-1:0] s;
      s = ($urandom_range(0, 1) == 0) ? NUM_SRC'(1 << $urandom_range(0, NUM_SRC - 1)) : NUM_SRC'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, AW'($urandom), s,
           rand_src(), $urandom_range(0, 1) == 1);
    end

    // Drain and confirm nothing is left outstanding
    for (int n = 0; n < 10; n++) idle(1);
    chk("drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
